// File: rtl/mitm_send_arbiter_if.sv
// Signal bundle for mitm_send_arbiter: forward request, injection queue and bus transmitter.
// master = the arbiter; slave = forwarding path, injector and bus transmitter model.
interface mitm_send_arbiter_if #(
    parameter int NUM_DATA_BITS = 8,
    parameter int FIFO_DEPTH    = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Handshakes: fwd_valid holds fwd_data until the cycle fwd_ack=1, when the byte is taken
    // (dropping fwd_valid earlier withdraws it). inj_wr pushes inj_data each cycle it is high.
    // send_ready=1 means the transmitter is idle; it drops to accept a fake_send_start pulse
    // and rises again when the byte is on the wire.
    logic                     fwd_valid;
    logic [NUM_DATA_BITS-1:0] fwd_data;
    logic                     fwd_ack;
    logic                     inj_wr;
    logic [NUM_DATA_BITS-1:0] inj_data;
    logic [CNT_W-1:0]         inj_count;
    logic                     inj_full;
    logic                     inj_overflow;
    logic                     send_ready;
    logic                     fake_send_select;
    logic                     fake_send_start;
    logic [NUM_DATA_BITS-1:0] fake_send_data;
    logic                     send_err;

    modport master (
        input  fwd_valid, fwd_data, inj_wr, inj_data, send_ready,
        output fwd_ack, inj_count, inj_full, inj_overflow,
               fake_send_select, fake_send_start, fake_send_data, send_err
    );

    modport slave (
        output fwd_valid, fwd_data, inj_wr, inj_data, send_ready,
        input  fwd_ack, inj_count, inj_full, inj_overflow,
               fake_send_select, fake_send_start, fake_send_data, send_err
    );
endinterface

// File: rtl/mitm_send_arbiter.sv
// Arbitrates forwarded and injected bytes onto the bus transmitter, one transfer at a time.
// Define ARB_ROUND_ROBIN_EN for alternating grants; otherwise forward has strict priority.
module mitm_send_arbiter #(
    parameter int NUM_DATA_BITS  = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int ACCEPT_TIMEOUT = 16
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    mitm_send_arbiter_if.master  bus,
    output logic [1:0]           dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(ACCEPT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LAUNCH      = 2'd1,
        WAIT_ACCEPT = 2'd2,
        WAIT_DONE   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         count_q;
    logic                     overflow_q;
    logic [NUM_DATA_BITS-1:0] send_data_q;
    logic [TMR_W-1:0]         timer_q;
    logic                     fifo_full, inj_pending;
    logic                     grant_fwd, grant_inj, timeout;
    logic                     push, pop;
`ifdef ARB_ROUND_ROBIN_EN
    logic                     rr_inj_q;
`endif

    assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign inj_pending = (count_q != '0);

    always_comb begin
        state_d   = state_q;
        grant_fwd = 1'b0;
        grant_inj = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst && bus.send_ready) begin
`ifdef ARB_ROUND_ROBIN_EN
                    // rr_inj_q only matters when both sides are waiting.
                    if (bus.fwd_valid && !(inj_pending && rr_inj_q)) grant_fwd = 1'b1;
                    else if (inj_pending)                            grant_inj = 1'b1;
`else
                    if (bus.fwd_valid)    grant_fwd = 1'b1;
                    else if (inj_pending) grant_inj = 1'b1;
`endif
                end
                if (grant_fwd || grant_inj) state_d = LAUNCH;
            end
            LAUNCH: state_d = WAIT_ACCEPT;
            WAIT_ACCEPT: begin
                if (!bus.send_ready) begin
                    state_d = WAIT_DONE;
                end else if (!rst && timer_q == TMR_W'(ACCEPT_TIMEOUT - 1)) begin
                    // The byte is dropped, not retried.
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: if (bus.send_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign pop  = grant_inj;
    assign push = bus.inj_wr && (!fifo_full || pop);

    always_ff @(posedge sys_clk) begin
        if (!rst && push) fifo_mem[wr_ptr_q] <= bus.inj_data;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            send_data_q <= '0;
            timer_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_inj_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
            if (bus.inj_wr && fifo_full && !pop) overflow_q <= 1'b1;
            // Head is read before a same-cycle push to a full queue overwrites that slot.
            if (grant_fwd)      send_data_q <= bus.fwd_data;
            else if (grant_inj) send_data_q <= fifo_mem[rd_ptr_q];
            timer_q <= (state_q == WAIT_ACCEPT) ? timer_q + TMR_W'(1) : '0;
`ifdef ARB_ROUND_ROBIN_EN
            if (grant_fwd)      rr_inj_q <= 1'b1;
            else if (grant_inj) rr_inj_q <= 1'b0;
`endif
        end
    end

    assign bus.fwd_ack          = grant_fwd;
    assign bus.inj_count        = count_q;
    assign bus.inj_full         = fifo_full;
    assign bus.inj_overflow     = overflow_q;
    assign bus.fake_send_select = (state_q != IDLE);
    assign bus.fake_send_start  = (state_q == LAUNCH);
    assign bus.fake_send_data   = send_data_q;
    assign bus.send_err         = timeout;
    assign dbg_state            = state_q;
endmodule

// File: tb/tb_mitm_send_arbiter.sv
// Directed self-checking bench for mitm_send_arbiter with a simple transmitter model.
module tb_mitm_send_arbiter;
  localparam int W = 8;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;
  int checks = 0;
  int failures = 0;

  mitm_send_arbiter_if #(.NUM_DATA_BITS(W), .FIFO_DEPTH(DEPTH)) bus ();

  mitm_send_arbiter #(.NUM_DATA_BITS(W), .FIFO_DEPTH(DEPTH), .ACCEPT_TIMEOUT(TIMEOUT)) dut (
    .sys_clk(clk),
    .rst(rst),
    .bus(bus.master),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- transmitter model + scoreboard capture ----------------
  logic [W-1:0] sent_q[$];
  logic [W-1:0] exp_q[$];
  int start_cnt = 0;
  int busy = 0;
  bit model_respond = 1'b1;
  int model_busy = 3;
  bit ready_level = 1'b1;
  int last_start = -100;
  int min_spacing = 1000;
  int data_viol = 0;
  logic prev_sel = 1'b0;
  logic [W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      busy = 0;
    end else if (bus.fake_send_start) begin
      start_cnt++;
      sent_q.push_back(bus.fake_send_data);
      if (cyc - last_start < min_spacing) min_spacing = cyc - last_start;
      last_start = cyc;
      if (model_respond) busy = model_busy;
    end
    if (bus.fake_send_select && prev_sel && bus.fake_send_data !== prev_data) data_viol++;
    prev_sel = bus.fake_send_select;
    prev_data = bus.fake_send_data;
    if (busy > 0) begin
      bus.send_ready = 1'b0;
      busy--;
    end else begin
      bus.send_ready = ready_level;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    bus.inj_wr = 1'b1;
    bus.inj_data = d;
    tick();
    bus.inj_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.fwd_valid = 1'b0;
    bus.inj_wr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.inj_wr = 1'b1;
    bus.inj_data = 8'hEE;
    tick();
    tick();
    rst = 1'b0;
    bus.inj_wr = 1'b0;
    #1;
    checks++; if (bus.inj_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.inj_count); end
    checks++; if (bus.inj_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.inj_full); end
    checks++; if (bus.inj_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.inj_overflow); end
    checks++; if (bus.fake_send_select !== 1'b0) begin failures++; $display("FAIL reset_select got=%b exp=0", bus.fake_send_select); end
    checks++; if (bus.fake_send_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", bus.fake_send_start); end
    checks++; if (bus.fake_send_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.fake_send_data); end
    checks++; if (bus.fwd_ack !== 1'b0 || bus.send_err !== 1'b0) begin failures++; $display("FAIL reset_pulses ack=%b err=%b exp=0/0", bus.fwd_ack, bus.send_err); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    tick();
    checks++; if (bus.inj_count !== 3'd0) begin failures++; $display("FAIL reset_push_ignored got=%0d exp=0", bus.inj_count); end
  endtask

  task automatic test_single_forward();
    int k;
    model_respond = 1'b1;
    model_busy = 10;
    ready_level = 1'b1;
    do_reset();
    bus.fwd_valid = 1'b1;
    bus.fwd_data = 8'hA5;
    #1;
    checks++; if (bus.fwd_ack !== 1'b1) begin failures++; $display("FAIL fwd_ack_grant got=%b exp=1", bus.fwd_ack); end
    tick();
    bus.fwd_valid = 1'b0;
    bus.fwd_data = 8'h00;
    #1;
    checks++; if (bus.fake_send_start !== 1'b1 || bus.fake_send_select !== 1'b1) begin
      failures++; $display("FAIL fwd_launch start=%b select=%b exp=1/1", bus.fake_send_start, bus.fake_send_select); end
    checks++; if (bus.fake_send_data !== 8'hA5) begin failures++; $display("FAIL fwd_data got=%h exp=a5", bus.fake_send_data); end
    checks++; if (bus.fwd_ack !== 1'b0) begin failures++; $display("FAIL fwd_ack_once got=%b exp=0", bus.fwd_ack); end
    k = 0;
    while (bus.fake_send_select === 1'b1 && k < 40) begin
      tick();
      k++;
      if (k == 1) begin
        checks++; if (bus.fake_send_start !== 1'b0 || dbg_state !== 2'd2) begin
          failures++; $display("FAIL fwd_start_width start=%b state=%0d exp=0/2", bus.fake_send_start, dbg_state); end
      end
    end
    checks++; if (k != 11) begin failures++; $display("FAIL fwd_select_release cycles=%0d exp=11", k); end
  endtask

  task automatic test_queue_order();
    int base, idx, k;
    logic [W-1:0] e, got;
    model_respond = 1'b1;
    model_busy = 3;
    ready_level = 1'b0;
    do_reset();
    tick();
    base = sent_q.size();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    #1;
    checks++; if (bus.inj_count !== 3'd3 || bus.inj_full !== 1'b0) begin
      failures++; $display("FAIL queue_fill count=%0d full=%b exp=3/0", bus.inj_count, bus.inj_full); end
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    ready_level = 1'b1;
    k = 0;
    while (!(sent_q.size() - base >= 3 && dbg_state == 2'd0) && k < 200) begin tick(); k++; end
    checks++; if (sent_q.size() - base != 3) begin failures++; $display("FAIL queue_sent_count got=%0d exp=3", sent_q.size() - base); end
    idx = base;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (idx < sent_q.size()) ? sent_q[idx] : {W{1'bx}};
      checks++; if (got !== e) begin failures++; $display("FAIL queue_order[%0d] got=%h exp=%h", idx - base, got, e); end
      idx++;
    end
    checks++; if (bus.inj_count !== 3'd0) begin failures++; $display("FAIL queue_drain count=%0d exp=0", bus.inj_count); end
  endtask

  task automatic test_overflow();
    int base, idx, k;
    logic [W-1:0] e, got;
    model_respond = 1'b1;
    model_busy = 3;
    ready_level = 1'b0;
    do_reset();
    tick();
    base = sent_q.size();
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    #1;
    checks++; if (bus.inj_full !== 1'b1 || bus.inj_overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_full full=%b overflow=%b exp=1/0", bus.inj_full, bus.inj_overflow); end
    push(8'hA4);
    #1;
    checks++; if (bus.inj_count !== 3'd4 || bus.inj_full !== 1'b1 || bus.inj_overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_drop count=%0d full=%b overflow=%b exp=4/1/1", bus.inj_count, bus.inj_full, bus.inj_overflow); end
    // Push lands on the same edge as the first pop of the full queue.
    ready_level = 1'b1;
    @(negedge clk);
    #1;
    bus.inj_wr = 1'b1;
    bus.inj_data = 8'hB0;
    tick();
    bus.inj_wr = 1'b0;
    #1;
    checks++; if (bus.inj_count !== 3'd4 || dbg_state !== 2'd1) begin
      failures++; $display("FAIL ovf_push_pop count=%0d state=%0d exp=4/1", bus.inj_count, dbg_state); end
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3); exp_q.push_back(8'hB0);
    k = 0;
    while (!(sent_q.size() - base >= 5 && dbg_state == 2'd0) && k < 300) begin tick(); k++; end
    repeat (10) tick();
    checks++; if (sent_q.size() - base != 5) begin failures++; $display("FAIL ovf_sent_count got=%0d exp=5", sent_q.size() - base); end
    idx = base;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (idx < sent_q.size()) ? sent_q[idx] : {W{1'bx}};
      checks++; if (got !== e) begin failures++; $display("FAIL ovf_order[%0d] got=%h exp=%h", idx - base, got, e); end
      idx++;
    end
    do_reset();
    checks++; if (bus.inj_overflow !== 1'b0) begin failures++; $display("FAIL ovf_reset_clear got=%b exp=0", bus.inj_overflow); end
  endtask

  task automatic test_contention();
    int base, idx, k, n;
    logic [W-1:0] e, got;
    model_respond = 1'b1;
    model_busy = 3;
    ready_level = 1'b0;
    do_reset();
    tick();
    base = sent_q.size();
    push(8'h01);
    push(8'h02);
    bus.fwd_valid = 1'b1;
    bus.fwd_data = 8'hF0;
    ready_level = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    n = 4;
    exp_q.push_back(8'hF0); exp_q.push_back(8'h01); exp_q.push_back(8'hF0); exp_q.push_back(8'h02);
    k = 0;
    while (sent_q.size() - base < 4 && k < 200) begin tick(); k++; end
    bus.fwd_valid = 1'b0;
    repeat (30) tick();
`else
    n = 5;
    exp_q.push_back(8'hF0); exp_q.push_back(8'hF0); exp_q.push_back(8'hF0);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    k = 0;
    while (sent_q.size() - base < 3 && k < 200) begin tick(); k++; end
    checks++; if (bus.inj_count !== 3'd2) begin failures++; $display("FAIL prio_inj_held count=%0d exp=2", bus.inj_count); end
    bus.fwd_valid = 1'b0;
    k = 0;
    while (!(sent_q.size() - base >= 5 && dbg_state == 2'd0) && k < 200) begin tick(); k++; end
    repeat (10) tick();
`endif
    checks++; if (sent_q.size() - base != n) begin failures++; $display("FAIL contention_count got=%0d exp=%0d", sent_q.size() - base, n); end
    idx = base;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (idx < sent_q.size()) ? sent_q[idx] : {W{1'bx}};
      checks++; if (got !== e) begin failures++; $display("FAIL contention_order[%0d] got=%h exp=%h", idx - base, got, e); end
      idx++;
    end
    checks++; if (bus.inj_count !== 3'd0) begin failures++; $display("FAIL contention_drain count=%0d exp=0", bus.inj_count); end
  endtask

  task automatic test_timeout();
    int k, t0, t1;
    model_respond = 1'b0;
    ready_level = 1'b1;
    do_reset();
    push(8'h5A);
    push(8'h5B);
    k = 0;
    while (bus.fake_send_start !== 1'b1 && k < 10) begin tick(); k++; end
    t0 = cyc;
    checks++; if (bus.fake_send_data !== 8'h5A) begin failures++; $display("FAIL timeout_first_data got=%h exp=5a", bus.fake_send_data); end
    k = 0;
    while (bus.send_err !== 1'b1 && k < 40) begin tick(); k++; end
    t1 = cyc;
    checks++; if (t1 - t0 != TIMEOUT) begin failures++; $display("FAIL timeout_delay cycles=%0d exp=%0d", t1 - t0, TIMEOUT); end
    tick();
    checks++; if (dbg_state !== 2'd0 || bus.send_err !== 1'b0) begin
      failures++; $display("FAIL timeout_idle state=%0d err=%b exp=0/0", dbg_state, bus.send_err); end
    tick();
    checks++; if (bus.fake_send_start !== 1'b1 || bus.fake_send_data !== 8'h5B) begin
      failures++; $display("FAIL timeout_next start=%b data=%h exp=1/5b", bus.fake_send_start, bus.fake_send_data); end
  endtask

  task automatic test_reset_mid();
    int k, s0;
    model_respond = 1'b1;
    model_busy = 10;
    ready_level = 1'b1;
    do_reset();
    bus.fwd_valid = 1'b1;
    bus.fwd_data = 8'hC3;
    tick();
    bus.fwd_valid = 1'b0;
    k = 0;
    while (dbg_state !== 2'd3 && k < 10) begin tick(); k++; end
    checks++; if (dbg_state !== 2'd3) begin failures++; $display("FAIL mid_wait_done state=%0d exp=3", dbg_state); end
    push(8'h77);
    #1;
    checks++; if (bus.inj_count !== 3'd1) begin failures++; $display("FAIL mid_push_busy count=%0d exp=1", bus.inj_count); end
    rst = 1'b1;
    tick();
    checks++; if (bus.fake_send_select !== 1'b0 || bus.fake_send_start !== 1'b0 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL mid_abort select=%b start=%b state=%0d exp=0/0/0", bus.fake_send_select, bus.fake_send_start, dbg_state); end
    checks++; if (bus.inj_count !== 3'd0) begin failures++; $display("FAIL mid_flush count=%0d exp=0", bus.inj_count); end
    rst = 1'b0;
    s0 = start_cnt;
    repeat (20) tick();
    checks++; if (start_cnt != s0) begin failures++; $display("FAIL mid_no_start starts=%0d exp=%0d", start_cnt, s0); end
  endtask

  task automatic test_invariants();
    checks++; if (min_spacing < 4) begin failures++; $display("FAIL start_spacing min=%0d exp>=4", min_spacing); end
    checks++; if (data_viol != 0) begin failures++; $display("FAIL data_stable violations=%0d exp=0", data_viol); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    bus.fwd_valid = 1'b0;
    bus.fwd_data = '0;
    bus.inj_wr = 1'b0;
    bus.inj_data = '0;
    test_reset();
    test_single_forward();
    test_queue_order();
    test_overflow();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mitm_send_arbiter.md
MITM_SEND_ARBITER -- requirements
Module: mitm_send_arbiter

Interface
REQ-001 SHALL have parameter NUM_DATA_BITS, default 8: width of every data byte.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: injection queue entries; power of two, minimum 2.
REQ-003 SHALL have parameter ACCEPT_TIMEOUT, default 16: cycles to wait for send_ready to drop after a start pulse.
REQ-004 SHALL have port sys_clk  in  1  single system clock; all logic on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port fwd_valid  in  1  forwarded (MITM-modified) byte pending.
REQ-007 SHALL have port fwd_data  in  NUM_DATA_BITS  forwarded byte.
REQ-008 SHALL have port fwd_ack  out  1  one-cycle pulse: forwarded byte taken.
REQ-009 SHALL have port inj_wr  in  1  push inj_data into the injection queue.
REQ-010 SHALL have port inj_data  in  NUM_DATA_BITS  injected byte.
REQ-011 SHALL have port inj_count  out  clog2(FIFO_DEPTH)+1  queue occupancy.
REQ-012 SHALL have port inj_full  out  1  inj_count == FIFO_DEPTH.
REQ-013 SHALL have port inj_overflow  out  1  sticky flag: a push was dropped.
REQ-014 SHALL have port send_ready  in  1  transmitter idle, from the bus interface.
REQ-015 SHALL have port fake_send_select  out  1  selects fake data on the bus transmitter.
REQ-016 SHALL have port fake_send_start  out  1  one-cycle transmit start.
REQ-017 SHALL have port fake_send_data  out  NUM_DATA_BITS  byte being transmitted.
REQ-018 SHALL have port send_err  out  1  one-cycle pulse on accept timeout.

Function
REQ-019 SHALL implement FSM IDLE -> LAUNCH -> WAIT_ACCEPT -> WAIT_DONE -> IDLE.
REQ-020 IDLE: when send_ready=1 and (fwd_valid=1 or inj_count>0), SHALL grant one requester, register its byte into fake_send_data and enter LAUNCH; when either condition is unmet, SHALL stay in IDLE.
REQ-021 Grant cycle: forward grant pulses fwd_ack; injection grant pops the FIFO head.
REQ-022 LAUNCH: fake_send_start=1 for exactly this cycle; next state WAIT_ACCEPT.
REQ-023 WAIT_ACCEPT: send_ready=0 -> WAIT_DONE; ACCEPT_TIMEOUT cycles without that -> pulse send_err and go to IDLE; the byte is discarded, not retried.
REQ-024 WAIT_DONE: send_ready=1 -> IDLE.
REQ-025 fake_send_select SHALL be 1 in LAUNCH, WAIT_ACCEPT and WAIT_DONE, and 0 in IDLE.
REQ-026 fake_send_data SHALL stay stable from grant until the return to IDLE.
REQ-027 Minimum spacing between consecutive start pulses: 4 cycles.
REQ-028 FIFO push when not full SHALL increment inj_count.
REQ-029 Push when full with no pop in the same cycle SHALL be dropped and SHALL set inj_overflow.
REQ-030 Push and pop in the same cycle SHALL both succeed and leave inj_count unchanged, including when the FIFO is full.
REQ-031 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 Pushes SHALL be accepted in every FSM state.
REQ-033 fwd_data SHALL be sampled only in the grant cycle.
REQ-034 fwd_valid deasserting before the grant SHALL cancel the forward request without error.

Reset
REQ-035 rst=1 SHALL force IDLE and SHALL empty the FIFO (inj_count=0, inj_full=0).
REQ-036 rst=1 SHALL clear fake_send_select, fake_send_start, fake_send_data, fwd_ack, send_err, inj_overflow and the round-robin pointer.
REQ-037 rst=1 mid-transfer SHALL abort with no further start pulse, and the in-flight byte SHALL be lost.
REQ-038 A push in a reset cycle SHALL be ignored.

Configuration
REQ-039 Macro ARB_ROUND_ROBIN_EN defined: when both requesters are pending, the grant SHALL alternate; the first such grant after reset goes to forward.
REQ-040 Macro ARB_ROUND_ROBIN_EN undefined: forward SHALL have strict priority; injection is granted only while fwd_valid=0.

Verification
REQ-041 Single forward: fwd_valid=1, fwd_data=0xA5, send_ready=1 -> fwd_ack at cycle N, start at N+1 with data 0xA5 and select=1; model drops send_ready for 10 cycles -> select=0 after send_ready returns.
REQ-042 Queue order: push 0x11, 0x22, 0x33 back-to-back, fwd_valid=0 -> three starts in order 0x11, 0x22, 0x33; inj_count 3 -> 0.
REQ-043 Overflow: 5 pushes with FIFO_DEPTH=4, send_ready held 0 -> inj_count=4, inj_full=1, inj_overflow=1; 5th byte never transmitted; reset clears inj_overflow.
REQ-044 Contention: fwd_valid held with 0xF0 and queue holding 0x01, 0x02 -> with ARB_ROUND_ROBIN_EN send order F0, 01, F0, 02; without it only F0 is sent while fwd_valid=1.
REQ-045 Timeout: send_ready held 1 after the start pulse -> send_err pulses 16 cycles later; FSM back in IDLE; next pending byte is granted.
REQ-046 Reset in WAIT_DONE -> select=0 the next cycle, no start pulse, inj_count=0.
